fb_wr_sched: RTL and testbench

FB_WR_SCHED -- requirements
Module: fb_wr_sched

---
 rtl/fb_wr_sched.sv | 231 +++++++++++++++++++++++
 tb/tb_fb_wr_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_wr_sched.sv
// fb_wr_sched -- framebuffer write scheduler
//
// Purpose: merges a stream of captured pixel writes, buffered in a small FIFO,
// with an optional screen-clear engine onto a single registered RAM write port.
// Capture writes win arbitration, but the clear engine is forced through after
// STARVE_MAX consecutive losses so a busy capture stream cannot stall a clear.
//
// Optional feature: define FB_WR_CLEAR_EN to build the clear engine. Without
// it clr_start/clr_val are ignored, clr_busy/clr_done read 0 and the FIFO is
// drained whenever it holds data.
//
// Parameters:
//   FB_WORDS   number of 1-bit framebuffer locations
//   STARVE_MAX clear-engine losses tolerated before a forced clear grant
//   FIFO_DEPTH capture FIFO entries (power of two, at least 2)
//
// Ports:
//   vgaclk               single clock
//   reset_n              asynchronous active-low reset
//   cap_valid/cap_ready  capture write handshake
//   cap_addr/cap_data    capture pixel address and value
//   clr_start/clr_val    start-clear pulse and fill value
//   clr_busy/clr_done    clear in progress / one-cycle completion pulse
//   waddr/wdata/wren     registered framebuffer RAM write port
module fb_wr_sched #(
    parameter int FB_WORDS   = 192000,
    parameter int STARVE_MAX = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        vgaclk,
    input  logic        reset_n,
    input  logic        cap_valid,
    output logic        cap_ready,
    input  logic [17:0] cap_addr,
    input  logic        cap_data,
    input  logic        clr_start,
    input  logic        clr_val,
    output logic        clr_busy,
    output logic        clr_done,
    output logic [17:0] waddr,
    output logic        wdata,
    output logic        wren
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int LOSS_W = $clog2(STARVE_MAX + 2);
    localparam logic [17:0]       LAST_ADDR = 18'(FB_WORDS - 1);
    localparam logic [LOSS_W-1:0] LOSS_MAX  = LOSS_W'(STARVE_MAX);

    logic [18:0]      fifo_mem_q [FIFO_DEPTH];
    logic [18:0]      fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_empty, fifo_full;
    logic             push, pop;
    logic [18:0]      fifo_head;

    logic             grant_fifo, grant_clr;
    logic [17:0]      clr_addr;
    logic             clr_data;

    logic             wren_q, wren_d;
    logic [17:0]      waddr_q, waddr_d;
    logic             wdata_q, wdata_d;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign cap_ready  = !fifo_full;
    assign push       = cap_valid && !fifo_full;
    assign pop        = grant_fifo;
    assign fifo_head  = fifo_mem_q[rd_ptr_q];

    // Entries are {addr, data}; pointers wrap naturally for power-of-two depth.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = {cap_addr, cap_data};
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge vgaclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

`ifdef FB_WR_CLEAR_EN
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [17:0]       clr_cnt_q, clr_cnt_d;
    logic [LOSS_W-1:0] loss_q, loss_d;
    logic              clr_val_q, clr_val_d;
    logic              clr_done_q, clr_done_d;
    logic              clr_last;

    assign clr_last = (clr_cnt_q == LAST_ADDR);

    // Capture has priority; the clear engine wins when the FIFO is idle or
    // once it has lost STARVE_MAX times in a row.
    always_comb begin
        grant_clr  = (state_q == ST_CLEAR) && (fifo_empty || (loss_q == LOSS_MAX));
        grant_fifo = !fifo_empty && !grant_clr;
    end

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        loss_d     = loss_q;
        clr_val_d  = clr_val_q;
        clr_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                loss_d = '0;
                if (clr_start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                    clr_val_d = clr_val;
                end
            end
            ST_CLEAR: begin
                if (grant_clr) begin
                    loss_d = '0;
                    if (clr_last) begin
                        state_d    = ST_IDLE;
                        clr_cnt_d  = '0;
                        clr_done_d = 1'b1;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 18'(1);
                    end
                end else begin
                    // Not granted while in CLEAR means the FIFO took the slot.
                    loss_d = loss_q + LOSS_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge vgaclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            clr_cnt_q  <= '0;
            loss_q     <= '0;
            clr_val_q  <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            loss_q     <= loss_d;
            clr_val_q  <= clr_val_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign clr_addr = clr_cnt_q;
    assign clr_data = clr_val_q;
    assign clr_busy = (state_q == ST_CLEAR);
    assign clr_done = clr_done_q;
`else
    logic unused_cfg;

    assign grant_clr  = 1'b0;
    assign grant_fifo = !fifo_empty;
    assign clr_addr   = '0;
    assign clr_data   = 1'b0;
    assign clr_busy   = 1'b0;
    assign clr_done   = 1'b0;
    assign unused_cfg = ^{clr_start, clr_val, LAST_ADDR, LOSS_MAX};
`endif

    // Address/data hold their last value when nothing is granted.
    always_comb begin
        wren_d  = grant_fifo || grant_clr;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (grant_clr) begin
            waddr_d = clr_addr;
            wdata_d = clr_data;
        end else if (grant_fifo) begin
            waddr_d = fifo_head[18:1];
            wdata_d = fifo_head[0];
        end
    end

    always_ff @(posedge vgaclk or negedge reset_n) begin
        if (!reset_n) begin
            wren_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 1'b0;
        end else begin
            wren_q  <= wren_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign wren  = wren_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

endmodule

// File: tb/tb_fb_wr_sched.sv
// tb_fb_wr_sched -- directed bench for fb_wr_sched
//
// Drives fb_wr_sched (FB_WORDS=16, STARVE_MAX=3, FIFO_DEPTH=4) through reset,
// single and streamed captures and, when FB_WR_CLEAR_EN is defined, full
// clears, capture/clear arbitration, FIFO backpressure and reset mid-clear.
// Without FB_WR_CLEAR_EN the clear inputs must have no effect.
module tb_fb_wr_sched;

    localparam int FB_WORDS   = 16;
    localparam int STARVE_MAX = 3;
    localparam int FIFO_DEPTH = 4;

    logic        vgaclk = 1'b0;
    logic        reset_n;
    logic        cap_valid;
    logic        cap_ready;
    logic [17:0] cap_addr;
    logic        cap_data;
    logic        clr_start;
    logic        clr_val;
    logic        clr_busy;
    logic        clr_done;
    logic [17:0] waddr;
    logic        wdata;
    logic        wren;

    int vectors     = 0;
    int miscompares = 0;

    // Expected write port after each edge of the arbitration run: capture
    // entry k carries address 0x100+k and data k[0]; clear writes fill 0.
    localparam logic [17:0] FAIR_ADDR [18] = '{
        18'h100, 18'h101, 18'h102, 18'h000, 18'h103, 18'h104,
        18'h105, 18'h001, 18'h106, 18'h107, 18'h108, 18'h002,
        18'h109, 18'h10A, 18'h10B, 18'h003, 18'h10C, 18'h10D
    };
    localparam logic FAIR_DATA [18] = '{
        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1
    };

    fb_wr_sched #(
        .FB_WORDS   (FB_WORDS),
        .STARVE_MAX (STARVE_MAX),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .vgaclk    (vgaclk),
        .reset_n   (reset_n),
        .cap_valid (cap_valid),
        .cap_ready (cap_ready),
        .cap_addr  (cap_addr),
        .cap_data  (cap_data),
        .clr_start (clr_start),
        .clr_val   (clr_val),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .waddr     (waddr),
        .wdata     (wdata),
        .wren      (wren)
    );

    always #5 vgaclk = ~vgaclk;

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge vgaclk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [17:0] addr, input logic data,
                                 input logic start, input logic val);
        cap_valid = valid;
        cap_addr  = addr;
        cap_data  = data;
        clr_start = start;
        clr_val   = val;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkWrite(input string tag, input logic en, input logic [17:0] addr,
                              input logic data);
        checkOutput({tag, "_wren"}, 32'(wren), 32'(en));
        if (en) begin
            checkOutput({tag, "_waddr"}, 32'(waddr), 32'(addr));
            checkOutput({tag, "_wdata"}, 32'(wdata), 32'(data));
        end
    endtask

    initial begin
        int done_pulses;
        int k;

        reset_n = 1'b0;
        applyStimulus(1'b0, 18'h0, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("rst_wren", 32'(wren), 32'd0);
        checkOutput("rst_waddr", 32'(waddr), 32'd0);
        checkOutput("rst_wdata", 32'(wdata), 32'd0);
        checkOutput("rst_cap_ready", 32'(cap_ready), 32'd1);
        checkOutput("rst_clr_busy", 32'(clr_busy), 32'd0);
        checkOutput("rst_clr_done", 32'(clr_done), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        $display("[TB] single capture");
        applyStimulus(1'b1, 18'h00123, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 18'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("single_edge0_wren", 32'(wren), 32'd0);
        tick();
        checkWrite("single_edge1", 1'b1, 18'h00123, 1'b1);
        tick();
        checkOutput("single_edge2_wren", 32'(wren), 32'd0);
        checkOutput("single_hold_waddr", 32'(waddr), 32'h00123);
        checkOutput("single_hold_wdata", 32'(wdata), 32'd1);

        $display("[TB] streamed captures");
        for (int i = 0; i < 6; i++) begin
            if (i < 5) begin
                applyStimulus(1'b1, 18'h2A000 + 18'(i), ~i[0], 1'b0, 1'b0);
            end else begin
                applyStimulus(1'b0, 18'h0, 1'b0, 1'b0, 1'b0);
            end
            tick();
            checkOutput($sformatf("stream%0d_ready", i), 32'(cap_ready), 32'd1);
            if (i > 0) begin
                checkWrite($sformatf("stream%0d", i), 1'b1, 18'h2A000 + 18'(i - 1), i[0]);
            end
        end
        tick();
        checkOutput("stream_drained_wren", 32'(wren), 32'd0);

`ifdef FB_WR_CLEAR_EN
        $display("[TB] full clear with restart attempt");
        applyStimulus(1'b0, 18'h0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 18'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("clr_start_busy", 32'(clr_busy), 32'd1);
        checkOutput("clr_start_wren", 32'(wren), 32'd0);
        for (int i = 0; i < FB_WORDS; i++) begin
            applyStimulus(1'b0, 18'h0, 1'b0, (i == 5), 1'b0);
            tick();
            checkWrite($sformatf("clr%0d", i), 1'b1, 18'(i), 1'b1);
            checkOutput($sformatf("clr%0d_done", i), 32'(clr_done), 32'(i == FB_WORDS - 1));
            checkOutput($sformatf("clr%0d_busy", i), 32'(clr_busy), 32'(i != FB_WORDS - 1));
        end
        applyStimulus(1'b0, 18'h0, 1'b0, 1'b0, 1'b0);
        done_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (clr_done) done_pulses++;
            checkOutput($sformatf("clr_after%0d_wren", i), 32'(wren), 32'd0);
            checkOutput($sformatf("clr_after%0d_busy", i), 32'(clr_busy), 32'd0);
        end
        checkOutput("clr_extra_done", 32'(done_pulses), 32'd0);

        $display("[TB] arbitration and backpressure");
        applyStimulus(1'b1, 18'h100, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("fair_busy", 32'(clr_busy), 32'd1);
        checkOutput("fair_edge0_wren", 32'(wren), 32'd0);
        for (int n = 1; n <= 18; n++) begin
            if (n <= 14) begin
                k = (n == 14) ? 13 : n;
                applyStimulus(1'b1, 18'h100 + 18'(k), k[0], 1'b0, 1'b0);
            end else begin
                applyStimulus(1'b0, 18'h0, 1'b0, 1'b0, 1'b0);
            end
            tick();
            checkWrite($sformatf("fair%0d", n), 1'b1, FAIR_ADDR[n-1], FAIR_DATA[n-1]);
            checkOutput($sformatf("fair%0d_ready", n), 32'(cap_ready), 32'(n != 12));
        end
        done_pulses = 0;
        for (int i = 0; i < 40 && done_pulses == 0; i++) begin
            tick();
            if (clr_done) begin
                done_pulses++;
                checkWrite("fair_last_clear", 1'b1, 18'(FB_WORDS - 1), 1'b0);
            end
        end
        checkOutput("fair_done_seen", 32'(done_pulses), 32'd1);

        $display("[TB] reset mid-clear");
        applyStimulus(1'b0, 18'h0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 18'h0, 1'b0, 1'b0, 1'b0);
        repeat (7) tick();
        checkWrite("mid_before_rst", 1'b1, 18'd6, 1'b1);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_wren", 32'(wren), 32'd0);
        checkOutput("mid_rst_busy", 32'(clr_busy), 32'd0);
        checkOutput("mid_rst_done", 32'(clr_done), 32'd0);
        checkOutput("mid_rst_waddr", 32'(waddr), 32'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("mid_idle%0d_busy", i), 32'(clr_busy), 32'd0);
            checkOutput($sformatf("mid_idle%0d_done", i), 32'(clr_done), 32'd0);
            checkOutput($sformatf("mid_idle%0d_wren", i), 32'(wren), 32'd0);
        end
        applyStimulus(1'b0, 18'h0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 18'h0, 1'b0, 1'b0, 1'b1);
        tick();
        checkWrite("restart_first", 1'b1, 18'd0, 1'b0);
        done_pulses = 0;
        for (int i = 0; i < 40 && done_pulses == 0; i++) begin
            tick();
            if (clr_done) done_pulses++;
        end
        checkOutput("restart_done_seen", 32'(done_pulses), 32'd1);
`else
        $display("[TB] clear inputs ignored");
        applyStimulus(1'b1, 18'h3FFFF, 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 18'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("noclr_busy0", 32'(clr_busy), 32'd0);
        checkOutput("noclr_wren0", 32'(wren), 32'd0);
        tick();
        applyStimulus(1'b0, 18'h0, 1'b0, 1'b0, 1'b0);
        checkWrite("noclr_cap", 1'b1, 18'h3FFFF, 1'b1);
        checkOutput("noclr_busy1", 32'(clr_busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("noclr_idle%0d_wren", i), 32'(wren), 32'd0);
            checkOutput($sformatf("noclr_idle%0d_done", i), 32'(clr_done), 32'd0);
            checkOutput($sformatf("noclr_idle%0d_busy", i), 32'(clr_busy), 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
